// File: rtl/nios_mem_arb_pkg.sv
// Shared definitions for the on-chip RAM arbiter: port indices, read-return
// pipe record and default geometry of the 5120x32 RAM.
package nios_mem_arb_pkg;

    localparam int PORT_CPU    = 0;
    localparam int PORT_STREAM = 1;

    localparam int DEF_ADDR_W = 13;
    localparam int DEF_DEPTH  = 5120;

    typedef struct packed {
        logic valid;
        logic port;
        logic oor;
    } rd_pipe_t;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin grant with a saturating run-length record of the
// current owner. On a conflict the port that did not win last is served, so
// a waiting port is never held off for more than one cycle.
module mem_arb_rr2 #(
    parameter int  MAX_CONSEC = 4,
    localparam int CNT_W      = $clog2(MAX_CONSEC + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic             stall,
    output logic [1:0]       gnt,
    output logic             last,
    output logic [CNT_W-1:0] consec
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CONSEC);

    logic             last_q, last_d;
    logic [CNT_W-1:0] consec_q, consec_d;

    always_comb begin
        gnt      = 2'b00;
        last_d   = last_q;
        consec_d = consec_q;

        if (!stall) begin
            if (req == 2'b11) begin
                gnt = last_q ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end

        if (gnt != 2'b00) begin
            if (gnt[1] == last_q) begin
                if (consec_q != CNT_MAX) begin
                    consec_d = consec_q + CNT_W'(1);
                end
            end else begin
                last_d   = gnt[1];
                consec_d = CNT_W'(1);
            end
        end
    end

    // last resets to the stream port so the CPU wins the first conflict
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q   <= 1'b1;
            consec_q <= '0;
        end else begin
            last_q   <= last_d;
            consec_q <= consec_d;
        end
    end

    assign last   = last_q;
    assign consec = consec_q;

endmodule

// File: rtl/nios_onchip_memory_arbiter.sv
// Shares the single-port on-chip RAM between the CPU data master (m0) and the
// streaming engine (m1): one access per clock, fixed one-cycle read return.
module nios_onchip_memory_arbiter
    import nios_mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = 32,
    parameter int BE_W       = 4,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int MAX_CONSEC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reset_req,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    output logic              m0_error,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic              m1_error,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,

    output logic [15:0]       conflict_count
);

    localparam int                CNT_W     = $clog2(MAX_CONSEC + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_CONSEC);
    localparam logic [ADDR_W:0]   RANGE_LIM = (ADDR_W + 1)'(DEPTH);

    logic [1:0]       req, gnt;
    logic             stall, any_gnt, sel, sel_wr, in_range;
    logic [ADDR_W-1:0] sel_addr;
    logic             arb_last;
    logic [CNT_W-1:0] arb_consec;

    rd_pipe_t         pipe_q, pipe_d;
    logic [1:0]       err_q, err_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0] rd_data;

    assign req   = {m1_read | m1_write, m0_read | m0_write};
    assign stall = reset | reset_req;

    mem_arb_rr2 #(
        .MAX_CONSEC(MAX_CONSEC)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .stall  (stall),
        .gnt    (gnt),
        .last   (arb_last),
        .consec (arb_consec)
    );

    assign any_gnt  = |gnt;
    assign sel      = gnt[PORT_STREAM];
    assign sel_addr = sel ? m1_address : m0_address;
    assign sel_wr   = sel ? m1_write : m0_write;
    assign in_range = {1'b0, sel_addr} < RANGE_LIM;

    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        if (any_gnt) begin
            mem_address    = sel_addr;
            mem_byteenable = sel ? m1_byteenable : m0_byteenable;
            mem_writedata  = sel ? m1_writedata : m0_writedata;
            mem_chipselect = in_range;
            mem_write      = sel_wr & in_range;
        end

        m0_waitrequest = req[PORT_CPU] & ~gnt[PORT_CPU];
        m1_waitrequest = req[PORT_STREAM] & ~gnt[PORT_STREAM];

        // out-of-range accesses are accepted but only produce a pipe/error entry
        pipe_d = '0;
        if (any_gnt && !sel_wr) begin
            pipe_d.valid = 1'b1;
            pipe_d.port  = sel;
            pipe_d.oor   = ~in_range;
        end

        err_d = '0;
        if (any_gnt && !in_range) begin
            err_d = gnt;
        end

        cnt_d = cnt_q;
        if ((&req) && !reset_req && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_q <= '0;
            err_q  <= '0;
            cnt_q  <= '0;
        end else begin
            pipe_q <= pipe_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    // consec is zero only before the first grant, while last still holds its reset value
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ((arb_consec <= CNT_MAX) && ((arb_consec != '0) || arb_last));
        end
    end

    assign rd_data = (pipe_q.valid && !pipe_q.oor) ? mem_readdata : '0;

    assign m0_readdata      = rd_data;
    assign m1_readdata      = rd_data;
    assign m0_readdatavalid = pipe_q.valid & (pipe_q.port == 1'(PORT_CPU));
    assign m1_readdatavalid = pipe_q.valid & (pipe_q.port == 1'(PORT_STREAM));
    assign m0_error         = err_q[PORT_CPU];
    assign m1_error         = err_q[PORT_STREAM];
    assign conflict_count   = cnt_q;

endmodule
